// File: rtl/rom_uart_loader_pkg.sv
// Shared definitions for the HACK ROM serial loader: receiver state encoding
// and the bit-timing derivations used by the UART receiver.
package rom_uart_loader_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rxState_e;

  localparam int DEFAULT_CLK_HZ = 50_000_000;
  localparam int DEFAULT_BAUD   = 500_000;

  function automatic int clksPerBit(input int clkHz, input int baud);
    return clkHz / baud;
  endfunction

  function automatic int halfBit(input int cpb);
    return cpb / 2;
  endfunction

  function automatic int cntWidth(input int cpb);
    return (cpb <= 2) ? 1 : $clog2(cpb);
  endfunction

endpackage

// File: rtl/rom_uart_loader_uart_rx_byte.sv
// 8N1 serial byte receiver: input synchronizer, start/data/stop FSM and
// LSB-first shift register, producing single-cycle byte_valid/frame_err pulses.
module uart_rx_byte
  import rom_uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int CNT_W = cntWidth(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(halfBit(CLKS_PER_BIT) - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  logic             sync1_q, sync2_q, prev_q;
  rxState_e         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             errWait_q, errWait_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bitIdx_q  <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      errWait_q <= 1'b0;
    end else begin
      sync1_q   <= rx_i;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitIdx_q  <= bitIdx_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      errWait_q <= errWait_d;
    end
  end

  // After a bad stop bit the FSM parks in STOP until the line returns high,
  // so a stuck-low line cannot be mistaken for a fresh start bit.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitIdx_d  = bitIdx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    errWait_d = errWait_q;
    case (state_q)
      RX_IDLE: begin
        cnt_d     = '0;
        errWait_d = 1'b0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d    = '0;
          bitIdx_d = '0;
          state_d  = sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {sync2_q, shift_q[7:1]};
          if (bitIdx_q == 3'd7) state_d = RX_STOP;
          else                  bitIdx_d = bitIdx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (errWait_q) begin
          if (sync2_q) state_d = RX_IDLE;
        end else if (cnt_q == FULL_M1) begin
          cnt_d = '0;
          if (sync2_q) begin
            valid_d = 1'b1;
            state_d = RX_IDLE;
          end else begin
            ferr_d    = 1'b1;
            errWait_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/rom_uart_loader.sv
// HACK instruction-ROM load port writer: packs serial bytes (high first) into
// 16-bit words with auto-incrementing address. Optional idle timeout: ROMLD_TIMEOUT_EN.
module rom_uart_loader
  import rom_uart_loader_pkg::*;
#(
  parameter int CLK_HZ         = DEFAULT_CLK_HZ,
  parameter int BAUD           = DEFAULT_BAUD,
  parameter int ADDR_W         = 15,
  parameter int TIMEOUT_CYCLES = 5_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              avr_tx,
  output logic [15:0]       rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_load,
  output logic              busy,
  output logic              frame_err
);

  localparam int CLKS_PER_BIT = clksPerBit(CLK_HZ, BAUD);

  logic [7:0] rxByte;
  logic       byteValid;
  logic       timeout;

  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       romData_q, romData_d;
  logic [ADDR_W-1:0] romAddr_q, romAddr_d;
  logic              romLoad_q, romLoad_d;
  logic              busy_q, busy_d;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_i         (avr_tx),
    .byte_o       (rxByte),
    .byte_valid_o (byteValid),
    .frame_err_o  (frame_err)
  );

`ifdef ROMLD_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] TO_M1 = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_q, idle_d;

  assign timeout = busy_q && (idle_q == TO_M1);

  always_comb begin
    idle_d = idle_q;
    if (byteValid || timeout) idle_d = '0;
    else if (busy_q)          idle_d = idle_q + IDLE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) idle_q <= '0;
    else        idle_q <= idle_d;
  end
`else
  logic unusedTimeoutParam;
  assign unusedTimeoutParam = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  // Address advances the cycle after the strobe and wraps naturally at 2^ADDR_W.
  always_comb begin
    phase_d   = phase_q;
    hi_d      = hi_q;
    addr_d    = addr_q;
    romData_d = romData_q;
    romAddr_d = romAddr_q;
    romLoad_d = 1'b0;
    busy_d    = busy_q;
    if (timeout) begin
      phase_d = 1'b0;
      addr_d  = '0;
      busy_d  = 1'b0;
    end else begin
      if (romLoad_q) addr_d = addr_q + ADDR_W'(1);
      if (frame_err) begin
        phase_d = 1'b0;
      end else if (byteValid) begin
        if (!phase_q) begin
          hi_d    = rxByte;
          phase_d = 1'b1;
          busy_d  = 1'b1;
        end else begin
          romData_d = {hi_q, rxByte};
          romAddr_d = addr_q;
          romLoad_d = 1'b1;
          phase_d   = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q   <= 1'b0;
      hi_q      <= '0;
      addr_q    <= '0;
      romData_q <= '0;
      romAddr_q <= '0;
      romLoad_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      hi_q      <= hi_d;
      addr_q    <= addr_d;
      romData_q <= romData_d;
      romAddr_q <= romAddr_d;
      romLoad_q <= romLoad_d;
      busy_q    <= busy_d;
    end
  end

  assign rom_data = romData_q;
  assign rom_addr = romAddr_q;
  assign rom_load = romLoad_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_rom_uart_loader.sv
// Directed self-checking bench for rom_uart_loader with a shortened bit time
// (50 clocks per bit) and a 2-bit address to exercise wrap-around.
module tb_rom_uart_loader;

  localparam int CLK_HZ         = 5_000_000;
  localparam int BAUD           = 100_000;
  localparam int CPB            = 50;
  localparam int ADDR_W         = 2;
  localparam int TIMEOUT_CYCLES = 2000;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              avr_tx = 1'b1;
  logic [15:0]       rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_load;
  logic              busy;
  logic              frame_err;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0]       dataQ[$];
  logic [ADDR_W-1:0] addrQ[$];
  int                ferrCount = 0;

  rom_uart_loader #(
    .CLK_HZ        (CLK_HZ),
    .BAUD          (BAUD),
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .avr_tx   (avr_tx),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .rom_load (rom_load),
    .busy     (busy),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Capture every strobe and frame-error pulse, sampled away from the active edge.
  always @(negedge clk) begin
    if (rom_load) begin
      dataQ.push_back(rom_data);
      addrQ.push_back(rom_addr);
    end
    if (frame_err) ferrCount++;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    avr_tx = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      avr_tx = b[i];
      waitCycles(CPB);
    end
    avr_tx = stopBit;
    waitCycles(CPB);
    avr_tx = 1'b1;
    waitCycles(10);
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    avr_tx = 1'b1;
    waitCycles(3);
    vectors++;
    if ({rom_data, rom_addr, rom_load, busy, frame_err} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: data=%h addr=%0d load=%b busy=%b ferr=%b, required all 0",
               rom_data, rom_addr, rom_load, busy, frame_err);
    end
    rst_n = 1'b1;
    waitCycles(5);
  endtask

  task automatic test_basic_words;
    int base;
    base = dataQ.size();
    sendByte(8'h12, 1'b1);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_after_first_byte: got %b, required 1", busy);
    end
    sendByte(8'h34, 1'b1);
    sendByte(8'hAB, 1'b1);
    sendByte(8'hCD, 1'b1);
    vectors++;
    if (dataQ.size() !== base + 2) begin
      miscompares++;
      $display("[TB] FAIL basic_load_count: got %0d, required %0d", dataQ.size() - base, 2);
    end else begin
      vectors++;
      if (dataQ[base] !== 16'h1234 || addrQ[base] !== 2'd0) begin
        miscompares++;
        $display("[TB] FAIL word0: data=%h addr=%0d, required 1234 @ 0", dataQ[base], addrQ[base]);
      end
      vectors++;
      if (dataQ[base+1] !== 16'hABCD || addrQ[base+1] !== 2'd1) begin
        miscompares++;
        $display("[TB] FAIL word1: data=%h addr=%0d, required abcd @ 1", dataQ[base+1], addrQ[base+1]);
      end
    end
    vectors++;
    if (rom_data !== 16'hABCD || rom_addr !== 2'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_after_load: data=%h addr=%0d busy=%b, required abcd 1 1",
               rom_data, rom_addr, busy);
    end
  endtask

  task automatic test_glitch;
    int loads, ferrs;
    loads = dataQ.size();
    ferrs = ferrCount;
    avr_tx = 1'b0;
    waitCycles(20);
    avr_tx = 1'b1;
    waitCycles(12 * CPB);
    vectors++;
    if (dataQ.size() !== loads || ferrCount !== ferrs) begin
      miscompares++;
      $display("[TB] FAIL glitch: loads=%0d ferrs=%0d, required 0 0", dataQ.size() - loads, ferrCount - ferrs);
    end
  endtask

  task automatic test_frame_error;
    int base, ferrs;
    base  = dataQ.size();
    ferrs = ferrCount;
    sendByte(8'h12, 1'b0);
    vectors++;
    if (ferrCount !== ferrs + 1) begin
      miscompares++;
      $display("[TB] FAIL frame_err_pulse: got %0d pulses, required 1", ferrCount - ferrs);
    end
    // A good high byte followed by a bad frame must be dropped for resync.
    sendByte(8'h99, 1'b1);
    sendByte(8'h12, 1'b0);
    sendByte(8'h56, 1'b1);
    sendByte(8'h78, 1'b1);
    vectors++;
    if (ferrCount !== ferrs + 2) begin
      miscompares++;
      $display("[TB] FAIL frame_err_count: got %0d, required 2", ferrCount - ferrs);
    end
    vectors++;
    if (dataQ.size() !== base + 1) begin
      miscompares++;
      $display("[TB] FAIL frame_err_loads: got %0d, required 1", dataQ.size() - base);
    end else begin
      vectors++;
      if (dataQ[base] !== 16'h5678 || addrQ[base] !== 2'd2) begin
        miscompares++;
        $display("[TB] FAIL resync_word: data=%h addr=%0d, required 5678 @ 2", dataQ[base], addrQ[base]);
      end
    end
  endtask

  task automatic test_wrap;
    int base;
    logic [ADDR_W-1:0] expAddr[5];
    expAddr = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    base = dataQ.size();
    for (int i = 0; i < 5; i++) begin
      sendByte(8'hC0 + 8'(i), 1'b1);
      sendByte(8'h10 + 8'(i), 1'b1);
    end
    vectors++;
    if (dataQ.size() !== base + 5) begin
      miscompares++;
      $display("[TB] FAIL wrap_count: got %0d, required 5", dataQ.size() - base);
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (addrQ[base+i] !== expAddr[i] || dataQ[base+i] !== {8'hC0 + 8'(i), 8'h10 + 8'(i)}) begin
          miscompares++;
          $display("[TB] FAIL wrap_word%0d: data=%h addr=%0d, required %h @ %0d", i,
                   dataQ[base+i], addrQ[base+i], {8'hC0 + 8'(i), 8'h10 + 8'(i)}, expAddr[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midsession;
    int base;
    sendByte(8'h77, 1'b1);
    rst_n = 1'b0;
    waitCycles(3);
    vectors++;
    if ({rom_data, rom_addr, rom_load, busy} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: data=%h addr=%0d load=%b busy=%b, required all 0",
               rom_data, rom_addr, rom_load, busy);
    end
    rst_n = 1'b1;
    waitCycles(5);
    base = dataQ.size();
    sendByte(8'hBE, 1'b1);
    sendByte(8'hEF, 1'b1);
    vectors++;
    if (dataQ.size() !== base + 1) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_loads: got %0d, required 1", dataQ.size() - base);
    end else begin
      vectors++;
      if (dataQ[base] !== 16'hBEEF || addrQ[base] !== 2'd0) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_word: data=%h addr=%0d, required beef @ 0", dataQ[base], addrQ[base]);
      end
    end
  endtask

`ifdef ROMLD_TIMEOUT_EN
  task automatic test_timeout;
    int base;
    rst_n = 1'b0;
    waitCycles(3);
    rst_n = 1'b1;
    waitCycles(5);
    sendByte(8'h01, 1'b1);
    sendByte(8'h02, 1'b1);
    sendByte(8'h03, 1'b1);
    sendByte(8'h04, 1'b1);
    sendByte(8'hEE, 1'b1);
    waitCycles(1500);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL busy_before_timeout: got %b, required 1", busy);
    end
    waitCycles(600);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL busy_after_timeout: got %b, required 0", busy);
    end
    base = dataQ.size();
    sendByte(8'h00, 1'b1);
    sendByte(8'h07, 1'b1);
    vectors++;
    if (dataQ.size() !== base + 1) begin
      miscompares++;
      $display("[TB] FAIL timeout_loads: got %0d, required 1", dataQ.size() - base);
    end else begin
      vectors++;
      if (dataQ[base] !== 16'h0007 || addrQ[base] !== 2'd0 || busy !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL timeout_new_image: data=%h addr=%0d busy=%b, required 0007 @ 0 busy 1",
                 dataQ[base], addrQ[base], busy);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic_words;
    test_glitch;
    test_frame_error;
    test_wrap;
    test_reset_midsession;
`ifdef ROMLD_TIMEOUT_EN
    test_timeout;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
